condicionador_sensores: RTL and testbench

Input-conditioning stage that sits directly upstream of the irrigation top level. It takes the six raw field sensor lines (tank level H/M/L, air humidity, soil humidity, temperature) and synchronises and debounces each one. It then checks that the H/M/L level pattern is physically plausible before the level and irrigation logic consume it. Outputs are clean, glitch-free copies of the sensors plus a persistent sensor-fault flag and a change strobe.

---
 rtl/condicionador_sensores_pkg.sv | 28 ++
 rtl/condicionador_sensores_debounce_bit.sv | 79 +++++++
 rtl/condicionador_sensores.sv | 158 +++++++++++++++
 tb/tb_condicionador_sensores.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/condicionador_sensores_pkg.sv
// ----------------------------------------------------------------------------
// condicionador_sensores_pkg
//   Shared definitions for the sensor-conditioning stage: fault FSM state
//   encoding, the four physically possible tank-level patterns {H,M,L} and a
//   helper that classifies a pattern as plausible.
// ----------------------------------------------------------------------------
package condicionador_sensores_pkg;

    typedef enum logic [1:0] {
        OK       = 2'd0,
        SUSPEITO = 2'd1,
        ERRO     = 2'd2,
        RECUPERA = 2'd3
    } estado_t;

    // Probes are stacked L (bottom) < M < H (top): water can only wet a
    // higher probe if every lower probe is also wet.
    localparam logic [2:0] NIVEL_VAZIO = 3'b000;
    localparam logic [2:0] BAIXO       = 3'b001;
    localparam logic [2:0] MEDIO       = 3'b011;
    localparam logic [2:0] CHEIO       = 3'b111;

    function automatic logic nivel_plausivel(input logic [2:0] hml);
        return (hml == NIVEL_VAZIO) || (hml == BAIXO) ||
               (hml == MEDIO)       || (hml == CHEIO);
    endfunction

endpackage

// File: rtl/condicionador_sensores_debounce_bit.sv
// ----------------------------------------------------------------------------
// debounce_bit
//   Conditions one raw sensor line: 2-flop synchroniser, optional 3-sample
//   majority filter, then a stability counter that lets the output follow
//   the input only after DEB_CYCLES consecutive differing samples.
//
//   Optional feature: define FILTRO_MAIORIA_EN to insert the majority vote
//   (adds two edges of latency, suppresses single-cycle spikes).
//
// Ports
//   clk        in   system clock
//   reiniciar  in   synchronous active-high reset
//   raw        in   asynchronous raw sensor line
//   out        out  debounced value
// ----------------------------------------------------------------------------
module debounce_bit
    import condicionador_sensores_pkg::*;
#(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic reiniciar,
    input  logic raw,
    output logic out
);

    localparam int              CW      = $clog2(DEB_CYCLES) + 1;
    localparam logic [CW-1:0]   CNT_FIM = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          amostra;
    logic [CW-1:0] cnt;

    // NOTE: sequential state is always assigned with <= so every flop
    // samples pre-edge values; with = the second stage would copy the first
    // stage's new value and the synchroniser would collapse to one flop.
    always_ff @(posedge clk) begin
        if (reiniciar) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

`ifdef FILTRO_MAIORIA_EN
    logic [2:0] hist;

    always_ff @(posedge clk) begin
        if (reiniciar) begin
            hist <= 3'b000;
        end else begin
            hist <= {hist[1:0], sync2};
        end
    end

    assign amostra = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
`else
    assign amostra = sync2;
`endif

    // Any sample equal to the current output restarts the stability count.
    always_ff @(posedge clk) begin
        if (reiniciar) begin
            cnt <= '0;
            out <= 1'b0;
        end else if (amostra == out) begin
            cnt <= '0;
        end else if (cnt == CNT_FIM) begin
            out <= amostra;
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/condicionador_sensores.sv
// ----------------------------------------------------------------------------
// condicionador_sensores
//   Input-conditioning stage ahead of the irrigation controller. Debounces
//   the six field sensors, checks the tank-level pattern for plausibility,
//   keeps a persistence-filtered level-sensor fault flag and pulses a change
//   strobe whenever any conditioned output moves.
//
//   Optional feature: FILTRO_MAIORIA_EN (see debounce_bit).
//
// Ports
//   clk                  in   system clock
//   reiniciar            in   synchronous active-high reset
//   H_raw, M_raw, L_raw  in   raw level probes (1 = water at probe)
//   Ua_raw, Us_raw, T_raw in  raw air humidity / soil humidity / temperature
//   H, M, L, Ua, Us, T   out  debounced sensor values
//   nivel_valido         out  debounced {H,M,L} is a plausible pattern
//   erro_sensor          out  persistent level-sensor fault (registered)
//   mudou                out  one-cycle pulse after any debounced output toggles
// ----------------------------------------------------------------------------
module condicionador_sensores
    import condicionador_sensores_pkg::*;
#(
    parameter int DEB_CYCLES = 50000,
    parameter int ERR_HOLD   = 100000
) (
    input  logic clk,
    input  logic reiniciar,
    input  logic H_raw,
    input  logic M_raw,
    input  logic L_raw,
    input  logic Ua_raw,
    input  logic Us_raw,
    input  logic T_raw,
    output logic H,
    output logic M,
    output logic L,
    output logic Ua,
    output logic Us,
    output logic T,
    output logic nivel_valido,
    output logic erro_sensor,
    output logic mudou
);

    localparam int               CNT_W   = $clog2((DEB_CYCLES > ERR_HOLD) ? DEB_CYCLES : ERR_HOLD) + 1;
    localparam logic [CNT_W-1:0] ERR_FIM = CNT_W'(ERR_HOLD - 1);

    logic [5:0] raw_vec;
    logic [5:0] deb;
    logic [5:0] deb_ant;

    assign raw_vec = {H_raw, M_raw, L_raw, Ua_raw, Us_raw, T_raw};

    for (genvar i = 0; i < 6; i++) begin : g_deb
        debounce_bit #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk       (clk),
            .reiniciar (reiniciar),
            .raw       (raw_vec[i]),
            .out       (deb[i])
        );
    end

    assign {H, M, L, Ua, Us, T} = deb;

    // ---------------------------------------------------------------- fault FSM
    estado_t          estado;
    estado_t          estado_prox;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_prox;
    logic             erro_prox;
    logic             plausivel;

    assign plausivel    = nivel_plausivel(deb[5:3]);
    assign nivel_valido = plausivel;

    always_ff @(posedge clk) begin
        if (reiniciar) begin
            estado      <= OK;
            cnt         <= '0;
            erro_sensor <= 1'b0;
        end else begin
            estado      <= estado_prox;
            cnt         <= cnt_prox;
            erro_sensor <= erro_prox;
        end
    end

    // NOTE: both outputs get a default before the case so no path leaves
    // them unassigned; otherwise synthesis infers latches.
    always_comb begin
        estado_prox = estado;
        cnt_prox    = cnt;
        case (estado)
            OK: begin
                if (!plausivel) begin
                    estado_prox = SUSPEITO;
                    cnt_prox    = CNT_W'(1);
                end else begin
                    cnt_prox    = '0;
                end
            end
            SUSPEITO: begin
                if (plausivel) begin
                    estado_prox = OK;
                    cnt_prox    = '0;
                end else if (cnt == ERR_FIM) begin
                    estado_prox = ERRO;
                    cnt_prox    = '0;
                end else begin
                    cnt_prox    = cnt + CNT_W'(1);
                end
            end
            ERRO: begin
                if (plausivel) begin
                    estado_prox = RECUPERA;
                    cnt_prox    = CNT_W'(1);
                end else begin
                    cnt_prox    = '0;
                end
            end
            RECUPERA: begin
                if (!plausivel) begin
                    estado_prox = ERRO;
                    cnt_prox    = '0;
                end else if (cnt == ERR_FIM) begin
                    estado_prox = OK;
                    cnt_prox    = '0;
                end else begin
                    cnt_prox    = cnt + CNT_W'(1);
                end
            end
            default: begin
                estado_prox = OK;
                cnt_prox    = '0;
            end
        endcase
    end

    // Flag follows the state being entered, so it is registered together
    // with the state and changes on the very edge that enters ERRO / OK.
    always_comb begin
        erro_prox = (estado_prox == ERRO) || (estado_prox == RECUPERA);
    end

    // ------------------------------------------------------------ change strobe
    always_ff @(posedge clk) begin
        if (reiniciar) begin
            deb_ant <= '0;
            mudou   <= 1'b0;
        end else begin
            deb_ant <= deb;
            mudou   <= |(deb ^ deb_ant);
        end
    end

endmodule

// File: tb/tb_condicionador_sensores.sv
// ----------------------------------------------------------------------------
// tb_condicionador_sensores
//   Scoreboard bench for condicionador_sensores with DEB_CYCLES=4,
//   ERR_HOLD=8. Each stimulus cycle feeds a behavioural model that predicts
//   all nine outputs after the coming edge; the prediction is queued and a
//   separate monitor pops and compares it just after that edge.
//
//   Model rules (per edge e, numbering edges from 1):
//     s(e)   = raw sampled two edges earlier (0 if a reset lies in between)
//     out    toggles at e when the last DEB_CYCLES values of s, none older
//            than the last reset, all differ from out
//     erro   rises after ERR_HOLD consecutive illegal registered patterns,
//            falls after ERR_HOLD consecutive legal ones while in fault
//     mudou  is high the cycle after an edge on which some output toggled
// ----------------------------------------------------------------------------
module tb_condicionador_sensores;

    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int MAXC = 8192;

    localparam int B_H  = 5;
    localparam int B_M  = 4;
    localparam int B_L  = 3;
    localparam int B_US = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reiniciar;
    logic H_raw, M_raw, L_raw, Ua_raw, Us_raw, T_raw;
    logic H, M, L, Ua, Us, T;
    logic nivel_valido, erro_sensor, mudou;

    condicionador_sensores #(
        .DEB_CYCLES (DEB),
        .ERR_HOLD   (HOLD)
    ) dut (
        .clk          (clk),
        .reiniciar    (reiniciar),
        .H_raw        (H_raw),
        .M_raw        (M_raw),
        .L_raw        (L_raw),
        .Ua_raw       (Ua_raw),
        .Us_raw       (Us_raw),
        .T_raw        (T_raw),
        .H            (H),
        .M            (M),
        .L            (L),
        .Ua           (Ua),
        .Us           (Us),
        .T            (T),
        .nivel_valido (nivel_valido),
        .erro_sensor  (erro_sensor),
        .mudou        (mudou)
    );

    // --------------------------------------------------------------- scoreboard
    logic [8:0] esperado_q[$];
    int         checks   = 0;
    int         failures = 0;

    // ------------------------------------------------------------ model state
    logic [5:0] raw_arr [MAXC];
    logic       rst_arr [MAXC];
    logic [5:0] s_arr   [MAXC];
    int         n        = 0;
    int         last_rst = 0;
    logic [5:0] m_out    = '0;
    logic       m_err    = 1'b0;
    logic       m_mudou  = 1'b0;
    logic       m_chg    = 1'b0;
    int         ill_run  = 0;
    int         leg_run  = 0;
    logic [5:0] raw_cur;

    function automatic logic legal(input logic [2:0] p);
        return (p == 3'b000) || (p == 3'b001) || (p == 3'b011) || (p == 3'b111);
    endfunction

    task automatic model_step(input logic [5:0] rv, input logic rst);
        logic [5:0] nxt;
        logic       todos;
        n = n + 1;
        raw_arr[n] = rv;
        rst_arr[n] = rst;
        if (n < 3)
            s_arr[n] = '0;
        else if (rst_arr[n-1] || rst_arr[n-2])
            s_arr[n] = '0;
        else
            s_arr[n] = raw_arr[n-2];

        if (rst) begin
            m_out    = '0;
            m_err    = 1'b0;
            m_mudou  = 1'b0;
            m_chg    = 1'b0;
            ill_run  = 0;
            leg_run  = 0;
            last_rst = n;
        end else begin
            m_mudou = m_chg;
            if (legal(m_out[5:3])) begin
                leg_run = leg_run + 1;
                ill_run = 0;
            end else begin
                ill_run = ill_run + 1;
                leg_run = 0;
            end
            if (!m_err && ill_run == HOLD)
                m_err = 1'b1;
            else if (m_err && leg_run == HOLD)
                m_err = 1'b0;

            nxt = m_out;
            if (n - DEB + 1 > last_rst) begin
                for (int b = 0; b < 6; b++) begin
                    todos = 1'b1;
                    for (int k = n - DEB + 1; k <= n; k++)
                        if (s_arr[k][b] == m_out[b]) todos = 1'b0;
                    if (todos) nxt[b] = ~m_out[b];
                end
            end
            m_chg = (nxt != m_out);
            m_out = nxt;
        end
        esperado_q.push_back({m_out, legal(m_out[5:3]), m_err, m_mudou});
    endtask

    // Drives one cycle of stimulus, predicts the response of the next edge
    // and returns two time units after that edge.
    task automatic cycle(input logic [5:0] rv, input logic rst);
        {H_raw, M_raw, L_raw, Ua_raw, Us_raw, T_raw} = rv;
        reiniciar = rst;
        model_step(rv, rst);
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) cycle(raw_cur, 1'b0);
    endtask

    // ---------------------------------------------------------------- monitor
    initial begin : monitor
        logic [8:0] exp_v;
        logic [8:0] got_v;
        int         ciclo;
        ciclo = 0;
        forever begin
            @(posedge clk);
            #1;
            ciclo = ciclo + 1;
            got_v = {H, M, L, Ua, Us, T, nivel_valido, erro_sensor, mudou};
            checks = checks + 1;
            if (esperado_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL scoreboard_vazio edge=%0d got=%b required=prediction", ciclo, got_v);
            end else begin
                exp_v = esperado_q.pop_front();
                if (got_v !== exp_v) begin
                    failures = failures + 1;
                    $display("FAIL saidas edge=%0d got={HMLUaUsT,nv,erro,mudou}=%b required=%b",
                             ciclo, got_v, exp_v);
                end
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    initial begin : stimulus
        int r;
        int bit_sel;
        logic [5:0] pulso;

        // Reset with all raw lines high, then release and let them pass.
        raw_cur = 6'h3F;
        repeat (3) cycle(raw_cur, 1'b1);
        run(10);
        raw_cur = 6'h00;
        run(12);

        // Glitch rejection on Us, then a clean pulse that gets through.
        raw_cur[B_US] = 1'b1; run(3);
        raw_cur[B_US] = 1'b0; run(10);
        raw_cur[B_US] = 1'b1; run(10);
        raw_cur[B_US] = 1'b0; run(10);

        // Tank filling L -> M -> H.
        raw_cur[B_L] = 1'b1; run(20);
        raw_cur[B_M] = 1'b1; run(20);
        raw_cur[B_H] = 1'b1; run(20);

        // Transient 010 while M leads L by three cycles.
        raw_cur = 6'h00; run(12);
        raw_cur[B_M] = 1'b1; run(3);
        raw_cur[B_L] = 1'b1; run(20);

        // Persistent 101, brief 111, 101 again, then a long 111.
        raw_cur[5:3] = 3'b101; run(20);
        raw_cur[5:3] = 3'b111; run(5);
        raw_cur[5:3] = 3'b101; run(10);
        raw_cur[5:3] = 3'b111; run(25);

        // Reset five cycles into a debounced 101; the count must restart.
        raw_cur[5:3] = 3'b101; run(11);
        repeat (2) cycle(raw_cur, 1'b1);
        run(25);
        raw_cur[5:3] = 3'b111; run(25);

        // Random phase: persistent flips, single-cycle spikes, rare resets.
        for (int i = 0; i < 2000; i++) begin
            r       = int'($urandom_range(0, 99));
            bit_sel = int'($urandom_range(0, 5));
            if ($urandom_range(0, 399) == 0) begin
                cycle(raw_cur, 1'b1);
            end else if (r < 6) begin
                raw_cur[bit_sel] = ~raw_cur[bit_sel];
                cycle(raw_cur, 1'b0);
            end else if (r < 10) begin
                pulso = raw_cur;
                pulso[bit_sel] = ~pulso[bit_sel];
                cycle(pulso, 1'b0);
            end else begin
                cycle(raw_cur, 1'b0);
            end
        end
        run(20);

        checks = checks + 1;
        if (esperado_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL scoreboard_residuo got=%0d pending required=0", esperado_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
